wb_sram_slave: RTL and testbench
================================

# wb_sram_slave

Wishbone classic-cycle responder: a word-addressed on-chip SRAM with byte-lane write enables, programmable wait states, and an error response for out-of-window or misaligned accesses. It is the slave-side counterpart to the opcode-driven Wishbone initiator our memory-controller benches use. It lets the same stimulus ROM flow exercise a known-good target. It sits on the system Wishbone bus beside `mc_top`, decoded by its own base window.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address bits; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYC`, default 1: wait states inserted before ack, legal range 0..15.
- `BASE`, default 32'h8000_0000: window base; only bits [31:ADDR_W+2] are compared.

Ports:
- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `wb_data_i` in 32: write data.
- `wb_data_o` out 32: read data; valid only while `wb_ack_o` is high, 0 otherwise.
- `wb_addr_i` in 32: byte address.
- `wb_sel_i` in 4: byte lanes; bit n covers data[8n+7:8n].
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe.
- `wb_ack_o` out 1: normal termination, a one-cycle pulse.
- `wb_err_o` out 1: error termination, a one-cycle pulse.
- `acc_cnt_o` out 16: acknowledged-transaction count. Present only with `WB_SLV_CNT_EN`.

## Operation
- A request is `wb_cyc_i & wb_stb_i` sampled in IDLE.
- Decode:
  - hit = `wb_addr_i[31:ADDR_W+2] == BASE[31:ADDR_W+2]` and `wb_addr_i[1:0] == 0`;
  - word index = `wb_addr_i[ADDR_W+1:2]`.
- FSM states: IDLE, WAIT, ACK, ERR, GAP.
- IDLE transitions:
  - request and miss -> ERR;
  - request and hit with `WAIT_CYC` = 0 -> ACK;
  - request and hit with `WAIT_CYC` > 0 -> WAIT, with the counter loaded to `WAIT_CYC` - 1.
- WAIT:
  - counter decrements each cycle;
  - counter at 0 -> ACK;
  - `wb_cyc_i` or `wb_stb_i` low in any WAIT cycle -> IDLE (abort: no write, no ack).
- ACK:
  - `wb_ack_o` = 1 for exactly one cycle;
  - read: `wb_data_o` = mem[index];
  - write: the edge leaving ACK writes each byte lane whose `wb_sel_i` bit is 1; the other lanes are unchanged;
  - next state is GAP.
- `wb_sel_i` = 0 on a write: the write is acked and no bytes change. On a read, `wb_sel_i` is ignored and the full word is returned.
- ERR: `wb_err_o` = 1 for one cycle, no memory access, next state is GAP.
- GAP: one dead cycle with ack and err low, then IDLE. A strobe still held during GAP is sampled in IDLE as a new request.
- The master holds address, data, `wb_sel_i` and `wb_we_i` stable from request until termination. The slave uses the values present in the ACK cycle.
- Memory is not reset; locations never written read as undefined.

## Timing
- Reset values: `wb_ack_o` = 0, `wb_err_o` = 0, `wb_data_o` = 0, state = IDLE, wait counter = 0, `acc_cnt_o` = 0.
- Request first visible at edge k:
  - ack is high in cycle k+1+`WAIT_CYC`;
  - err is high in cycle k+1, regardless of `WAIT_CYC`.
- Back-to-back requests with the strobe held high are spaced `WAIT_CYC` + 3 cycles apart (ack to ack).
- `rst_i` asserted in any state:
  - at the next edge the state returns to IDLE and ack, err and data go low;
  - a write whose ACK edge coincides with reset is discarded.
- `wb_ack_o` and `wb_err_o` are never high together.
- No combinational path from any input to any output.

## Configuration
- Macro `WB_SLV_CNT_EN`, defined: adds port `acc_cnt_o`.
  - Increments by 1 on every edge leaving ACK.
  - Saturates at 16'hFFFF.
  - Not incremented on ERR or abort.
  - Cleared by `rst_i`.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- Defaults. Write 32'hDEADBEEF to 32'h8000_0010 with sel=4'hF, then read the same address. Required: ack in cycle k+2 for each access; read returns 32'hDEADBEEF.
- Byte lanes. Write 32'h11223344 with sel=4'hF, write 32'hAABBCCDD with sel=4'b0101, then read. Required: read returns 32'h11BB33DD.
- Error. Read 32'h4000_0000 (out of window) and 32'h8000_0002 (misaligned). Required: err in cycle k+1, no ack, memory unchanged, counter unchanged.
- Abort. Build with `WAIT_CYC`=3; drop `wb_stb_i` one cycle after a write request. Required: no ack; a following read returns the old data.
- Back-to-back. Hold `wb_stb_i` high across 4 reads with `WAIT_CYC`=1. Required: acks exactly 4 cycles apart; `acc_cnt_o` = 4 with `WB_SLV_CNT_EN` defined.
- Reset mid-op. Assert `rst_i` during WAIT of a write. Required: ack, err and data are 0 the next cycle; location unchanged; `acc_cnt_o` = 0.

Source files
------------

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle SRAM responder: byte-lane writes, fixed wait states, error on miss.
// Optional macro WB_SLV_CNT_EN adds the saturating acknowledged-transaction counter acc_cnt_o.
module wb_sram_slave #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 1,
  parameter logic [31:0] BASE     = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_addr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
`ifdef WB_SLV_CNT_EN
  ,
  output logic [15:0] acc_cnt_o
`endif
);

  localparam int unsigned Words    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitLoad = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StWait, StAck, StErr, StGap} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [Words];
  logic                req;
  logic                hit;
  logic [ADDR_W-1:0]   idx;

  assign req = wb_cyc_i & wb_stb_i;
  assign hit = (wb_addr_i[31:ADDR_W+2] == BASE[31:ADDR_W+2]) && (wb_addr_i[1:0] == 2'b00);
  assign idx = wb_addr_i[ADDR_W+1:2];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (!hit) begin
            state_d = StErr;
          end else if (WAIT_CYC == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            wait_d  = WaitLoad;
          end
        end
      end
      StWait: begin
        // Master dropping the request mid-wait abandons the access silently.
        if (!req) begin
          state_d = StIdle;
          wait_d  = '0;
        end else if (wait_q == 4'd0) begin
          state_d = StAck;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StAck:   state_d = StGap;
      StErr:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // Address is held stable by the master, so fetching on the edge into ACK
      // returns the word addressed during the ACK cycle without a comb path.
      rdata_q <= (state_d == StAck && !wb_we_i) ? mem_q[idx] : '0;
    end
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == StAck && wb_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          mem_q[idx][8*b +: 8] <= wb_data_i[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o  = (state_q == StAck);
  assign wb_err_o  = (state_q == StErr);
  assign wb_data_o = rdata_q;

`ifdef WB_SLV_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == StAck && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign acc_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: two instances (WAIT_CYC 1 and 3) on a shared bus,
// selected by per-instance cyc, checked against a byte-level memory model.
module tb_wb_sram_slave;

  localparam int unsigned AW   = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned W0   = 1;
  localparam int unsigned W1   = 3;

  logic        clk;
  logic        rst;
  logic [31:0] wdat;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [1:0]  cyc;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata [2];
`ifdef WB_SLV_CNT_EN
  logic [15:0] cnt_o [2];
`endif

  int n_run;
  int n_fail;

  logic [31:0] mem_m [2][256];
  logic [3:0]  vld_m [2][256];
  int          cnt_m [2];

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        err;
    logic        chk;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [16];

  wb_sram_slave #(.ADDR_W(AW), .WAIT_CYC(W0), .BASE(BASE)) u_dut0 (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb_data_i (wdat),
    .wb_data_o (rdata[0]),
    .wb_addr_i (addr),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc[0]),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack[0]),
    .wb_err_o  (err[0])
`ifdef WB_SLV_CNT_EN
    ,
    .acc_cnt_o (cnt_o[0])
`endif
  );

  wb_sram_slave #(.ADDR_W(AW), .WAIT_CYC(W1), .BASE(BASE)) u_dut1 (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb_data_i (wdat),
    .wb_data_o (rdata[1]),
    .wb_addr_i (addr),
    .wb_sel_i  (sel),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc[1]),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack[1]),
    .wb_err_o  (err[1])
`ifdef WB_SLV_CNT_EN
    ,
    .acc_cnt_o (cnt_o[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? int'(W0) : int'(W1);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return ((a >> (AW + 2)) == (BASE >> (AW + 2))) && ((a % 4) == 0);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int d);
`ifdef WB_SLV_CNT_EN
    check(name, {16'b0, cnt_o[d]}, 32'(cnt_m[d]));
`else
    if (name.len() < 0 || d < 0) $display("unreachable");
`endif
  endtask

  // Drive one access from an IDLE-cycle negedge, wait for termination, then
  // step through GAP and the following IDLE cycle.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input string tag, output int lat,
                        output logic gack, output logic gerr, output logic [31:0] rd);
    addr   = a;
    wdat   = wd;
    sel    = s;
    we     = w;
    stb    = 1'b1;
    cyc[d] = 1'b1;
    lat    = 0;
    gack   = 1'b0;
    gerr   = 1'b0;
    rd     = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat  = i;
        gack = ack[d];
        gerr = err[d];
        rd   = rdata[d];
        break;
      end
    end
    stb    = 1'b0;
    cyc[d] = 1'b0;
    @(negedge clk);
    check({tag, " gap quiet"}, rdata[d] | {30'b0, ack[d], err[d]}, 32'h0);
    @(negedge clk);
  endtask

  task automatic run_op(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic exp_err, input logic chk_data,
                        input logic [31:0] exp_d, input string tag);
    int          lat;
    int          ix;
    logic        gack;
    logic        gerr;
    logic [31:0] rd;
    access(d, w, a, wd, s, tag, lat, gack, gerr, rd);
    check({tag, " term"}, {30'b0, gerr, gack}, exp_err ? 32'd2 : 32'd1);
    check({tag, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'(1 + wait_of(d)));
    if (!w && !exp_err && chk_data) check({tag, " rdata"}, rd, exp_d);
    if (m_hit(a)) begin
      ix = m_idx(a);
      cnt_m[d]++;
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            mem_m[d][ix][8*b +: 8] = wd[8*b +: 8];
            vld_m[d][ix][b]        = 1'b1;
          end
        end
      end
    end
    check_cnt({tag, " count"}, d);
  endtask

  initial begin : main
    int          last;
    int          nack;
    logic        seen;
    n_run  = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0;
      for (int i = 0; i < 256; i++) vld_m[d][i] = 4'h0;
    end

    tbl[0]  = '{0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h8000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
    tbl[5]  = '{0, 1'b0, 32'h4000_0000, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{0, 1'b0, 32'h8000_0002, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{0, 1'b1, 32'h8000_0022, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{0, 1'b0, 32'h8000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
    tbl[9]  = '{0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{0, 1'b0, 32'h8000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
    tbl[11] = '{1, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1, 1'b0, 32'h8000_0040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hCAFE_F00D};
    tbl[13] = '{1, 1'b1, 32'h8000_0400, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0};
    tbl[14] = '{1, 1'b1, 32'h8000_03FC, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1, 1'b0, 32'h8000_03FC, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0BAD_C0DE};

    rst  = 1'b1;
    wdat = '0;
    addr = '0;
    sel  = '0;
    we   = 1'b0;
    stb  = 1'b0;
    cyc  = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset outputs", rdata[d] | {30'b0, ack[d], err[d]}, 32'h0);
      check_cnt("reset count", d);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sel, tbl[i].err,
             tbl[i].chk, tbl[i].rdata, $sformatf("vec%0d", i));
    end

    // Abort: WAIT_CYC=3 instance, strobe dropped one cycle after the write request.
    addr   = 32'h8000_0040;
    wdat   = 32'h1234_5678;
    sel    = 4'hF;
    we     = 1'b1;
    stb    = 1'b1;
    cyc[1] = 1'b1;
    @(negedge clk);
    stb  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack[1] | err[1];
    end
    cyc[1] = 1'b0;
    check("abort no termination", {31'b0, seen}, 32'h0);
    @(negedge clk);
    run_op(1, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D, "abort readback");

    // Back-to-back reads with the strobe held high.
    addr   = 32'h8000_0010;
    we     = 1'b0;
    sel    = 4'hF;
    stb    = 1'b1;
    cyc[0] = 1'b1;
    last   = -1;
    nack   = 0;
    for (int i = 1; i <= 40 && nack < 4; i++) begin
      @(negedge clk);
      if (ack[0]) begin
        check("b2b rdata", rdata[0], 32'hDEAD_BEEF);
        if (last >= 0) check("b2b spacing", 32'(i - last), 32'(W0 + 3));
        last = i;
        nack++;
      end
    end
    stb    = 1'b0;
    cyc[0] = 1'b0;
    check("b2b ack count", 32'(nack), 32'd4);
    cnt_m[0] += 4;
    @(negedge clk);
    @(negedge clk);
    check_cnt("b2b count", 0);

    // Reset asserted while a write sits in WAIT.
    addr   = 32'h8000_0010;
    wdat   = 32'h5555_5555;
    sel    = 4'hF;
    we     = 1'b1;
    stb    = 1'b1;
    cyc[0] = 1'b1;
    @(negedge clk);
    rst    = 1'b1;
    stb    = 1'b0;
    cyc[0] = 1'b0;
    @(negedge clk);
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    for (int d = 0; d < 2; d++) begin
      check("midop reset outputs", rdata[d] | {30'b0, ack[d], err[d]}, 32'h0);
      check_cnt("midop reset count", d);
    end
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, "midop readback");

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int          d;
      int          r;
      int          ix;
      logic        w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  s;
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom();
      s  = 4'($urandom());
      a  = BASE + ($urandom_range(0, 255) << 2);
      if (r == 8) a = a + $urandom_range(1, 3);
      else if (r == 9) a = $urandom() & 32'h7FFF_FFFF;
      ix = m_idx(a);
      run_op(d, w, a, wd, s, !m_hit(a), vld_m[d][ix] == 4'hF, mem_m[d][ix], "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
